// File: rtl/pipelined_mult_unit.sv
// Purpose : fully pipelined signed/unsigned WIDTH x WIDTH multiplier producing the HI/LO product with a per-operation rd tag.
// Latency : STAGES cycles from issue to o_valid, including the issue cycle; one issue per cycle.
// Backpres: i_stall freezes every stage and drops the issue; i_flush kills all in-flight ops and the issue.
//
// Optional feature macro: MULT_OVF_EN (registered o_ovf flag). When undefined, o_ovf is tied low.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_valid/i_signed       issue request, operand signedness
//   i_a, i_b, i_rd         operands and destination tag
//   i_stall, i_flush       hold all stages / kill all stages
//   o_valid, o_hi, o_lo    final-stage result (product upper / lower half)
//   o_rd                   final-stage tag (0 when empty)
//   o_busy                 any stage occupied
//   o_stage_valid/_rd      per-stage valid and tag for hazard detection
//   o_ovf                  product does not fit in WIDTH bits
module pipelined_mult_unit #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int RD_W   = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic                   i_signed,
    input  logic [WIDTH-1:0]       i_a,
    input  logic [WIDTH-1:0]       i_b,
    input  logic [RD_W-1:0]        i_rd,
    input  logic                   i_stall,
    input  logic                   i_flush,
    output logic                   o_valid,
    output logic [WIDTH-1:0]       o_hi,
    output logic [WIDTH-1:0]       o_lo,
    output logic [RD_W-1:0]        o_rd,
    output logic                   o_busy,
    output logic [STAGES-1:0]      o_stage_valid,
    output logic [STAGES*RD_W-1:0] o_stage_rd,
    output logic                   o_ovf
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]   prod_q [STAGES];
    logic [RD_W-1:0] rd_q   [STAGES];
    logic [STAGES-1:0] vld_q;

    logic          issue;
    logic [PW-1:0] ext_a;
    logic [PW-1:0] ext_b;
    logic [PW-1:0] prod_full;

    assign issue = i_valid & ~i_stall & ~i_flush;

    // Extending both operands to the full product width lets one unsigned
    // multiply serve both modes: the low 2*WIDTH bits of a two's-complement
    // product are identical to those of the modular unsigned product.
    assign ext_a     = i_signed ? {{WIDTH{i_a[WIDTH-1]}}, i_a} : {{WIDTH{1'b0}}, i_a};
    assign ext_b     = i_signed ? {{WIDTH{i_b[WIDTH-1]}}, i_b} : {{WIDTH{1'b0}}, i_b};
    assign prod_full = ext_a * ext_b;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                prod_q[k] <= '0;
                rd_q[k]   <= '0;
            end
        end else if (i_flush) begin
            // Products are left as-is; valid and tag are what the core observes.
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                rd_q[k] <= '0;
            end
        end else if (!i_stall) begin
            vld_q[0]  <= issue;
            rd_q[0]   <= issue ? i_rd : '0;
            prod_q[0] <= issue ? prod_full : '0;
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k]  <= vld_q[k-1];
                rd_q[k]   <= rd_q[k-1];
                prod_q[k] <= prod_q[k-1];
            end
        end
    end

`ifdef MULT_OVF_EN
    logic [STAGES-1:0] ovf_q;
    logic              ovf_new;

    // Signed: HI must be a pure sign extension of LO's MSB.
    // Unsigned: HI must be zero.
    assign ovf_new = i_signed ? (prod_full[PW-1:WIDTH] != {WIDTH{prod_full[WIDTH-1]}})
                              : (prod_full[PW-1:WIDTH] != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            ovf_q <= '0;
        end else if (!i_stall) begin
            ovf_q[0] <= issue & ovf_new;
            for (int k = 1; k < STAGES; k++) begin
                ovf_q[k] <= ovf_q[k-1];
            end
        end
    end

    assign o_ovf = ovf_q[STAGES-1];
`else
    assign o_ovf = 1'b0;
`endif

    assign o_valid       = vld_q[STAGES-1];
    assign o_hi          = prod_q[STAGES-1][PW-1:WIDTH];
    assign o_lo          = prod_q[STAGES-1][WIDTH-1:0];
    assign o_rd          = rd_q[STAGES-1];
    assign o_busy        = |vld_q;
    assign o_stage_valid = vld_q;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage_rd
        assign o_stage_rd[g*RD_W +: RD_W] = rd_q[g];
    end

endmodule

// File: doc/pipelined_mult_unit.md
Name: pipelined_mult_unit

Overview:
Parametrised, fully pipelined integer multiplier for the MIPS execute path. Produces the full 2*WIDTH product split into HI and LO halves, in signed (MULT) or unsigned (MULTU) mode. Each in-flight operation carries a destination-register tag. Per-stage valid and rd tags are exported so the hazard unit can detect RAW dependencies against any stage. Supports pipeline stall and flush from the core.

Parameters:
WIDTH, 32, operand width in bits (>=2)
STAGES, 4, pipeline depth and issue-to-result latency in cycles (>=1)
RD_W, 5, destination register tag width

Ports:
i_clk  in  1  clock; one clock domain
i_rst  in  1  synchronous, active-high reset
i_valid  in  1  issue request; operands and tag are valid this cycle
i_signed  in  1  1 = two's-complement operands, 0 = unsigned
i_a  in  WIDTH  multiplicand
i_b  in  WIDTH  multiplier
i_rd  in  RD_W  destination tag carried with the operation
i_stall  in  1  freeze all stages
i_flush  in  1  kill all in-flight operations
o_valid  out  1  result valid in final stage
o_hi  out  WIDTH  product bits [2*WIDTH-1:WIDTH]
o_lo  out  WIDTH  product bits [WIDTH-1:0]
o_rd  out  RD_W  tag of the final-stage result
o_busy  out  1  OR of all stage valid bits
o_stage_valid  out  STAGES  valid bit per stage; bit 0 = first stage
o_stage_rd  out  STAGES*RD_W  rd tag per stage; stage k at [k*RD_W +: RD_W]
o_ovf  out  1  see Optional Feature

Behaviour:
- Reset is synchronous and active-high. While i_rst=1 at a clock edge, every stage valid, tag and product register clears to 0. All outputs read 0 after that edge.
- Issue: an operation is accepted on an edge where i_valid=1, i_stall=0 and i_flush=0.
- Stage 1 captures the full 2*WIDTH product, i_rd and valid=1.
- Sign handling: i_signed=1 sign-extends both operands to 2*WIDTH; i_signed=0 zero-extends them. The product is truncated to 2*WIDTH bits.
- Each unstalled edge shifts stage k to stage k+1. With no issue, stage 1 loads valid=0, tag=0, product=0.
- Latency: an operation issued at edge N appears on the outputs (o_valid=1) after edge N+STAGES-1, i.e. STAGES cycles including the issue cycle, when there are no stalls. Throughput is 1 per cycle.
- A stage with valid=0 always holds tag 0. o_rd and o_stage_rd are therefore 0 for empty stages, and rd=0 never creates a false hazard.
- Outputs o_hi, o_lo and o_rd are driven directly from the final-stage registers. There is no combinational path from inputs to outputs.
- Stall (i_stall=1, i_flush=0): all stage registers hold, and the issue is ignored. The caller must re-present the operation.
- Flush (i_flush=1): all valid bits and tags clear to 0 on that edge; product registers may hold. Flush overrides stall and issue on the same cycle, so the issue is dropped.
- Reset overrides flush, stall and issue.
- Results are presented for exactly one cycle unless stalled. The consumer must capture them when o_valid=1 and i_stall=0.
- STAGES=1: the product register is the output register; o_stage_* are 1 entry wide.

Optional Feature:
Macro MULT_OVF_EN.
- Defined: o_ovf is registered alongside the product and is valid when o_valid=1. o_ovf=1 when the product does not fit in WIDTH bits:
  - signed mode: o_hi is not all copies of o_lo[WIDTH-1];
  - unsigned mode: o_hi != 0.
  o_ovf=0 when o_valid=0. It is cleared by reset and flush.
- Not defined: o_ovf is tied to 0 and no overflow logic or register is built.

Test Plan (WIDTH=32, STAGES=4, RD_W=5):
1. Issue a=7, b=6, unsigned, rd=9, then idle -> 3 edges later o_valid=1, o_lo=42, o_hi=0, o_rd=9. o_stage_rd shows 9 moving through stages 0 to 3.
2. Signed a=0xFFFFFFFF (-1), b=2, rd=3 -> o_hi=0xFFFFFFFF, o_lo=0xFFFFFFFE. The same operands unsigned -> o_hi=0x00000001, o_lo=0xFFFFFFFE.
3. Back-to-back issues with rd=1,2,3,4 on consecutive cycles -> o_valid high for 4 consecutive cycles with o_rd=1,2,3,4 and correct products.
4. Issue rd=5, stall for 2 cycles after the first edge, then release -> the result appears 2 cycles late with no duplicate or lost result. An issue attempted during the stall is not accepted.
5. Flush with 3 operations in flight plus a simultaneous issue -> next cycle o_busy=0, all o_stage_valid=0, all o_stage_rd=0, and no later o_valid.
6. Assert i_rst mid-operation -> all outputs 0 after that edge. With MULT_OVF_EN defined, 0x10000*0x10000 unsigned -> o_ovf=1, and 3*4 -> o_ovf=0.
